// File: rtl/forward_ctrl.sv
// ---------------------------------------------------------------------------
// forward_ctrl
//
// Hazard controller for the EX-stage operand forwarding muxes and the
// load-use stall of the 5-stage RISC-V pipeline. The block keeps its own
// shadow copy of the destination-register state held in the ID/EX, EX/MEM
// and MEM/WB pipeline registers. From that state it selects the source of
// each EX operand and decides when IF/ID has to be held. It also counts
// stall cycles for performance debug.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   id_valid      ID stage holds a real instruction
//   id_rs1/rs2    source registers of the ID instruction
//   id_uses_rs1/2 ID instruction actually reads rs1 / rs2
//   id_rd         destination register of the ID instruction
//   id_reg_write  ID instruction writes rd
//   id_mem_read   ID instruction is a load
//   flush         taken branch/jump in EX: kill the ID instruction
//   stall         hold PC and IF/ID and insert a bubble into EX
//   forward_a     operand-A select: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   forward_b     operand-B select, same encoding
//   stall_count   saturating count of stall cycles since reset
// ---------------------------------------------------------------------------
module forward_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_uses_rs1,
   input  logic              id_uses_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              flush,
   output logic              stall,
   output logic [1:0]        forward_a,
   output logic [1:0]        forward_b,
   output logic [CNT_W-1:0]  stall_count
);

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   // EX record (mirror of ID/EX)
   logic              ex_valid_q,     ex_valid_d;
   logic              ex_uses_rs1_q,  ex_uses_rs1_d;
   logic              ex_uses_rs2_q,  ex_uses_rs2_d;
   logic              ex_reg_write_q, ex_reg_write_d;
   logic              ex_mem_read_q,  ex_mem_read_d;
   logic [REG_AW-1:0] ex_rs1_q,       ex_rs1_d;
   logic [REG_AW-1:0] ex_rs2_q,       ex_rs2_d;
   logic [REG_AW-1:0] ex_rd_q,        ex_rd_d;

   // MEM record (mirror of EX/MEM)
   logic              mem_valid_q,     mem_valid_d;
   logic              mem_reg_write_q, mem_reg_write_d;
   logic [REG_AW-1:0] mem_rd_q,        mem_rd_d;

   // WB record (mirror of MEM/WB)
   logic              wb_valid_q,     wb_valid_d;
   logic              wb_reg_write_q, wb_reg_write_d;
   logic [REG_AW-1:0] wb_rd_q,        wb_rd_d;

   logic [CNT_W-1:0]  stall_count_q,  stall_count_d;

   logic              hazard_rs1;
   logic              hazard_rs2;
   logic              stall_c;
   logic              issue;

   // A stage supplies register r only if it really writes it; x0 never
   // carries a forwarded value because it reads as zero.
   function automatic logic is_writer(
      input logic              valid,
      input logic              reg_write,
      input logic [REG_AW-1:0] rd,
      input logic [REG_AW-1:0] r
   );
      return valid & reg_write & (rd != '0) & (rd == r);
   endfunction

   // The newest producer wins: EX/MEM is checked before MEM/WB.
   function automatic logic [1:0] fwd_select(
      input logic              gate,
      input logic [REG_AW-1:0] src,
      input logic              m_valid,
      input logic              m_reg_write,
      input logic [REG_AW-1:0] m_rd,
      input logic              w_valid,
      input logic              w_reg_write,
      input logic [REG_AW-1:0] w_rd
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (gate) begin
         if (is_writer(m_valid, m_reg_write, m_rd, src)) begin
            sel = FWD_MEM;
         end else if (is_writer(w_valid, w_reg_write, w_rd, src)) begin
            sel = FWD_WB;
         end
      end
      return sel;
   endfunction

   // Load-use detection: a load in EX whose result the ID instruction
   // needs cannot be forwarded in time, so ID waits one cycle. A flush
   // kills the ID instruction, so there is nothing to wait for.
   always_comb begin
      hazard_rs1 = id_uses_rs1 & (id_rs1 == ex_rd_q);
      hazard_rs2 = id_uses_rs2 & (id_rs2 == ex_rd_q);
      stall_c    = ~flush & id_valid & ex_valid_q & ex_mem_read_q &
                   (ex_rd_q != '0) & (hazard_rs1 | hazard_rs2);
      issue      = id_valid & ~stall_c & ~flush;
   end

   assign stall = stall_c;

   // ID -> EX: a stalled or flushed instruction becomes a bubble with all
   // flags cleared. Register fields are copied regardless; they are only
   // looked at through the flags.
   always_comb begin
      ex_valid_d     = issue;
      ex_uses_rs1_d  = issue & id_uses_rs1;
      ex_uses_rs2_d  = issue & id_uses_rs2;
      ex_reg_write_d = issue & id_reg_write;
      ex_mem_read_d  = issue & id_mem_read;
      ex_rs1_d       = id_rs1;
      ex_rs2_d       = id_rs2;
      ex_rd_d        = id_rd;
   end

   // EX -> MEM -> WB advance unconditionally every cycle.
   always_comb begin
      mem_valid_d     = ex_valid_q;
      mem_reg_write_d = ex_reg_write_q;
      mem_rd_d        = ex_rd_q;
      wb_valid_d      = mem_valid_q;
      wb_reg_write_d  = mem_reg_write_q;
      wb_rd_d         = mem_rd_q;
   end

   // Saturating stall counter: holds at all-ones instead of wrapping.
   always_comb begin
      stall_count_d = stall_count_q;
      if (stall_c && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + CNT_W'(1);
      end
   end

   // Control state: validity and flags of every record, plus the counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid_q      <= 1'b0;
         ex_uses_rs1_q   <= 1'b0;
         ex_uses_rs2_q   <= 1'b0;
         ex_reg_write_q  <= 1'b0;
         ex_mem_read_q   <= 1'b0;
         mem_valid_q     <= 1'b0;
         mem_reg_write_q <= 1'b0;
         wb_valid_q      <= 1'b0;
         wb_reg_write_q  <= 1'b0;
         stall_count_q   <= '0;
      end else begin
         ex_valid_q      <= ex_valid_d;
         ex_uses_rs1_q   <= ex_uses_rs1_d;
         ex_uses_rs2_q   <= ex_uses_rs2_d;
         ex_reg_write_q  <= ex_reg_write_d;
         ex_mem_read_q   <= ex_mem_read_d;
         mem_valid_q     <= mem_valid_d;
         mem_reg_write_q <= mem_reg_write_d;
         wb_valid_q      <= wb_valid_d;
         wb_reg_write_q  <= wb_reg_write_d;
         stall_count_q   <= stall_count_d;
      end
   end

   // Register-number fields: meaningless while the matching valid is low,
   // so they need no reset.
   always_ff @(posedge clk) begin
      ex_rs1_q <= ex_rs1_d;
      ex_rs2_q <= ex_rs2_d;
      ex_rd_q  <= ex_rd_d;
      mem_rd_q <= mem_rd_d;
      wb_rd_q  <= wb_rd_d;
   end

   // Forward selects come only from registered state, so they settle
   // early in the cycle.
   always_comb begin
      forward_a = fwd_select(ex_valid_q & ex_uses_rs1_q, ex_rs1_q,
                             mem_valid_q, mem_reg_write_q, mem_rd_q,
                             wb_valid_q, wb_reg_write_q, wb_rd_q);
      forward_b = fwd_select(ex_valid_q & ex_uses_rs2_q, ex_rs2_q,
                             mem_valid_q, mem_reg_write_q, mem_rd_q,
                             wb_valid_q, wb_reg_write_q, wb_rd_q);
   end

   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_forward_ctrl.sv
module tb_forward_ctrl;

   localparam int REG_AW = 5;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              id_valid = 1'b0;
   logic [REG_AW-1:0] id_rs1 = '0;
   logic [REG_AW-1:0] id_rs2 = '0;
   logic              id_uses_rs1 = 1'b0;
   logic              id_uses_rs2 = 1'b0;
   logic [REG_AW-1:0] id_rd = '0;
   logic              id_reg_write = 1'b0;
   logic              id_mem_read = 1'b0;
   logic              flush = 1'b0;
   logic              stall;
   logic [1:0]        forward_a;
   logic [1:0]        forward_b;
   logic [CNT_W-1:0]  stall_count;

   always #5 clk = ~clk;

   forward_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .flush(flush), .stall(stall), .forward_a(forward_a), .forward_b(forward_b),
      .stall_count(stall_count)
   );

   // One in-flight instruction as seen by the hazard rules.
   typedef struct packed {
      logic       v;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       rw;
      logic       mr;
   } ins_t;

   // pipe[0] = EX, pipe[1] = MEM, pipe[2] = WB
   ins_t             pipe [3];
   ins_t             pipe_nx [3];
   logic [CNT_W-1:0] mcnt, mcnt_nx;
   bit               known, known_nx;

   int n_vec = 0;
   int n_err = 0;

   function automatic ins_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      ins_t t = '0;
      t.v = 1'b1; t.rs1 = rs1; t.rs2 = rs2; t.u1 = 1'b1; t.u2 = 1'b1; t.rd = rd; t.rw = 1'b1;
      return t;
   endfunction

   // Reads rs1 only; the rs2 field holds whatever the encoding leaves there.
   function automatic ins_t imm(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2f);
      ins_t t = '0;
      t.v = 1'b1; t.rs1 = rs1; t.rs2 = rs2f; t.u1 = 1'b1; t.rd = rd; t.rw = 1'b1;
      return t;
   endfunction

   function automatic ins_t ld(input logic [4:0] rd, input logic [4:0] rs1);
      ins_t t = imm(rd, rs1, 5'd0);
      t.mr = 1'b1;
      return t;
   endfunction

   function automatic ins_t bub();
      return '0;
   endfunction

   function automatic logic writes(input ins_t s, input logic [4:0] r);
      return s.v && s.rw && (s.rd != 5'd0) && (s.rd == r);
   endfunction

   // Youngest older instruction that writes r supplies the operand.
   function automatic logic [1:0] m_fwd(input logic want, input logic [4:0] r);
      if (!want) return 2'b00;
      for (int k = 1; k < 3; k++)
         if (writes(pipe[k], r)) return (k == 1) ? 2'b01 : 2'b10;
      return 2'b00;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Present one ID instruction for one cycle; compare at the falling edge.
   task automatic cyc(input ins_t i, input logic fl, input logic rst);
      logic       est;
      logic [1:0] efa, efb;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) pipe[k] = pipe_nx[k];
      mcnt  = mcnt_nx;
      known = known_nx;
      reset = rst; flush = fl;
      id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2;
      id_uses_rs1 = i.u1; id_uses_rs2 = i.u2; id_rd = i.rd;
      id_reg_write = i.rw; id_mem_read = i.mr;
      @(negedge clk);
      est = !fl && i.v && pipe[0].v && pipe[0].mr && (pipe[0].rd != 5'd0) &&
            ((i.u1 && i.rs1 == pipe[0].rd) || (i.u2 && i.rs2 == pipe[0].rd));
      efa = m_fwd(pipe[0].v && pipe[0].u1, pipe[0].rs1);
      efb = m_fwd(pipe[0].v && pipe[0].u2, pipe[0].rs2);
      if (known) begin
         n_vec++;
         if (stall !== est || forward_a !== efa || forward_b !== efb || stall_count !== mcnt) begin
            n_err++;
            $display("FAIL model t=%0t: stall=%b/%b fa=%b/%b fb=%b/%b cnt=%0d/%0d (got/expected)",
                     $time, stall, est, forward_a, efa, forward_b, efb, stall_count, mcnt);
         end
      end
      if (rst) begin
         for (int k = 0; k < 3; k++) pipe_nx[k] = '0;
         mcnt_nx  = '0;
         known_nx = 1'b1;
      end else begin
         pipe_nx[2] = pipe[1];
         pipe_nx[1] = pipe[0];
         pipe_nx[0] = (i.v && !est && !fl) ? i : bub();
         mcnt_nx    = (est && mcnt != '1) ? mcnt + 1'b1 : mcnt;
         known_nx   = known;
      end
   endtask

   task automatic step(input ins_t i);
      cyc(i, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] rr;
      ins_t        rnd;
      for (int k = 0; k < 3; k++) begin pipe[k] = '0; pipe_nx[k] = '0; end
      mcnt = '0; mcnt_nx = '0; known = 1'b0; known_nx = 1'b0;

      // Reset held two cycles with random ID content
      for (int k = 0; k < 2; k++) begin
         rr = $urandom;
         rnd = rr[19:0];
         cyc(rnd, 1'b0, 1'b1);
      end
      step(bub());
      chk("reset_fa", 32'(forward_a), 0);
      chk("reset_fb", 32'(forward_b), 0);
      chk("reset_stall", 32'(stall), 0);
      chk("reset_cnt", 32'(stall_count), 0);

      // Back-to-back ALU dependency: EX/MEM forward on operand A
      step(alu(5'd5, 5'd1, 5'd2));
      step(alu(5'd6, 5'd5, 5'd1));
      chk("exmem_nostall", 32'(stall), 0);
      step(bub());
      chk("exmem_fa", 32'(forward_a), 1);
      chk("exmem_fb", 32'(forward_b), 0);

      // One unrelated instruction in between: MEM/WB forward on operand B
      step(alu(5'd5, 5'd1, 5'd2));
      step(alu(5'd9, 5'd3, 5'd4));
      step(alu(5'd10, 5'd1, 5'd5));
      step(bub());
      chk("memwb_fa", 32'(forward_a), 0);
      chk("memwb_fb", 32'(forward_b), 2);

      // Two writers of x5: the younger one wins
      step(alu(5'd5, 5'd1, 5'd2));
      step(alu(5'd5, 5'd3, 5'd4));
      step(alu(5'd11, 5'd5, 5'd5));
      step(bub());
      chk("prio_fa", 32'(forward_a), 1);
      chk("prio_fb", 32'(forward_b), 1);

      // Load-use: one stall, then MEM/WB forward on both operands
      step(ld(5'd7, 5'd1));
      step(alu(5'd8, 5'd7, 5'd7));
      chk("lu_stall", 32'(stall), 1);
      chk("lu_cnt_before", 32'(stall_count), 0);
      step(alu(5'd8, 5'd7, 5'd7));
      chk("lu_stall_once", 32'(stall), 0);
      chk("lu_cnt", 32'(stall_count), 1);
      step(bub());
      chk("lu_fa", 32'(forward_a), 2);
      chk("lu_fb", 32'(forward_b), 2);

      // Load to x0 never stalls or forwards
      step(ld(5'd0, 5'd1));
      step(alu(5'd12, 5'd0, 5'd0));
      chk("x0_stall", 32'(stall), 0);
      step(bub());
      chk("x0_fa", 32'(forward_a), 0);
      chk("x0_fb", 32'(forward_b), 0);

      // Matching rs2 field that is not read
      step(alu(5'd13, 5'd1, 5'd2));
      step(imm(5'd14, 5'd3, 5'd13));
      step(bub());
      chk("unused_fa", 32'(forward_a), 0);
      chk("unused_fb", 32'(forward_b), 0);

      // Flush together with a load-use condition
      step(ld(5'd15, 5'd1));
      cyc(alu(5'd16, 5'd15, 5'd2), 1'b1, 1'b0);
      chk("flush_stall", 32'(stall), 0);
      step(alu(5'd17, 5'd15, 5'd15));
      chk("flush_bubble_fa", 32'(forward_a), 0);
      chk("flush_bubble_fb", 32'(forward_b), 0);
      chk("flush_cnt", 32'(stall_count), 1);

      // Reset while a writer sits in MEM discards it
      step(alu(5'd18, 5'd1, 5'd2));
      step(bub());
      cyc(bub(), 1'b0, 1'b1);
      step(alu(5'd19, 5'd18, 5'd18));
      step(bub());
      chk("rst_mid_fa", 32'(forward_a), 0);
      chk("rst_mid_fb", 32'(forward_b), 0);
      chk("rst_mid_cnt", 32'(stall_count), 0);

      // Drive the counter into saturation
      for (int k = 0; k < 17; k++) begin
         step(ld(5'd20, 5'd1));
         step(alu(5'd21, 5'd20, 5'd0));
         step(alu(5'd21, 5'd20, 5'd0));
      end
      step(bub());
      chk("sat_cnt", 32'(stall_count), 15);
      step(ld(5'd20, 5'd1));
      step(alu(5'd21, 5'd3, 5'd20));
      chk("sat_stall", 32'(stall), 1);
      step(alu(5'd21, 5'd3, 5'd20));
      chk("sat_hold", 32'(stall_count), 15);
      step(bub());
      chk("sat_fb", 32'(forward_b), 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/forward_ctrl.md
# forward_ctrl

Pipeline hazard controller that generates the select inputs for the 2-bit ALU-operand forwarding muxes in the EX stage and the load-use stall for the 5-stage RISC-V core. It mirrors the destination-register state of the ID/EX, EX/MEM and MEM/WB pipeline registers internally. From that state it decides, each cycle, whether each EX operand comes from the register file, the EX/MEM result or the MEM/WB result, and whether IF/ID must be held. It also keeps a saturating stall counter for performance debug.

## Interface
Parameters:
- REG_AW, 5, register address width (32 architectural registers; x0 hard-wired zero)
- CNT_W, 32, width of stall_count

Ports:
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  synchronous, active-high reset
- id_valid  input  1  ID stage holds a real instruction
- id_rs1  input  REG_AW  source register 1 of ID instruction
- id_rs2  input  REG_AW  source register 2 of ID instruction
- id_uses_rs1  input  1  ID instruction reads rs1
- id_uses_rs2  input  1  ID instruction reads rs2
- id_rd  input  REG_AW  destination of ID instruction
- id_reg_write  input  1  ID instruction writes rd
- id_mem_read  input  1  ID instruction is a load
- flush  input  1  branch/jump taken in EX; kill instruction in ID
- stall  output  1  hold PC and IF/ID; insert bubble into EX
- forward_a  output  2  operand-A mux select: 00 regfile, 01 EX/MEM, 10 MEM/WB
- forward_b  output  2  operand-B mux select, same encoding
- stall_count  output  CNT_W  number of stall cycles since reset, saturating

## Operation
- Internal stage records, one per stage:
  - EX: valid, rs1, rs2, uses_rs1, uses_rs2, rd, reg_write, mem_read.
  - MEM: valid, rd, reg_write.
  - WB: valid, rd, reg_write.
- Advance every cycle, with no global enable:
  - MEM <= EX.
  - WB <= MEM.
  - EX <= ID fields with valid = id_valid & ~stall & ~flush. Otherwise EX becomes a bubble (valid=0, all flags 0).
- Writer qualification: a stage qualifies as a writer for register r iff valid & reg_write & rd != 0 & rd == r.
- forward_a, computed from EX.rs1 with EX.valid & EX.uses_rs1:
  - MEM stage qualifies -> 01.
  - Else WB stage qualifies -> 10.
  - Else 00.
  - If the EX gating terms are 0 -> 00.
- forward_b: identical rule using EX.rs2 and EX.uses_rs2.
- Priority: EX/MEM (01) over MEM/WB (10) when both match; the newest value wins.
- stall = ~flush & id_valid & EX.valid & EX.mem_read & EX.rd != 0 & ((id_uses_rs1 & id_rs1 == EX.rd) | (id_uses_rs2 & id_rs2 == EX.rd)).
  - Combinational from ID inputs and EX record.
- flush overrides stall: stall is forced 0 and EX gets a bubble.
- A write in WB and a same-cycle read in ID are resolved by register-file write-through, not by this block.
- stall_count increments by 1 on each cycle with stall=1, saturates at all-ones and never wraps.
- Encoding 11 is never driven; the EX muxes treat it as 00.

## Timing
- Reset (reset=1 at a clk edge): all stage records cleared (valid=0).
  - Next cycle: forward_a=00, forward_b=00, stall=0, stall_count=0.
- Reset asserted mid-operation discards all in-flight records. There is no forwarding from pre-reset instructions.
- forward_a/forward_b depend only on registered state and are valid early in the cycle. stall has a combinational path from the id_* inputs.
- Load-use:
  - The load is in EX at cycle t and the consumer in ID -> stall=1 at t.
  - At t+1 EX holds a bubble, so stall=0.
  - At t+2 the consumer is in EX with forward=10.
  - Exactly one stall cycle per load-use pair.
- A back-to-back ALU dependency needs zero stalls: forward=01 in the consumer's EX cycle.
- Flush in cycle t: the EX record at t+1 is a bubble. The records already in EX/MEM advance normally.
- Simultaneous flush and load-use condition: stall=0, stall_count unchanged.

## Test plan
- Reset check: hold reset 2 cycles with random id_* -> forward_a=forward_b=00, stall=0, stall_count=0 on the first cycle after release.
- EX/MEM forward: `add x5,..` then `add x6,x5,x1` back-to-back -> forward_a=01 and forward_b=00 in the consumer's EX cycle; no stall.
- MEM/WB forward and priority:
  - With one unrelated instruction in between -> forward_b=10 when the consumer uses x5 as rs2.
  - Two successive writers of x5 followed by the consumer -> forward=01.
- Load-use: `lw x7` then `add x8,x7,x7` -> stall=1 for exactly one cycle, then forward_a=forward_b=10, stall_count=1.
- x0 and unused operands:
  - `lw x0` then a reader of x0 -> no stall, forward 00.
  - A consumer with id_uses_rs2=0 but a matching rs2 field -> forward_b=00.
- Flush and reset mid-stream:
  - flush in the same cycle as a load-use condition -> stall=0, next EX bubble, stall_count unchanged.
  - reset while a writer is in MEM -> forward 00 afterwards.
  - Force stall_count to all-ones -> it stays all-ones on a further stall.
